// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the MIPS multicycle controller.
// Contents: state codes, supported opcodes, ALUOp / ALUSrcB / PCSource encodings,
// the packed control word driven by the output decoder, and an opcode-legality helper.
// Optional feature macro used by the top: MC_MEM_WAIT_EN (memory wait states).
package mc_ctrl_pkg;

  // State register encoding (4-bit)
  typedef logic [3:0] state_t;
  localparam state_t ST_FETCH  = 4'd0;
  localparam state_t ST_DECODE = 4'd1;
  localparam state_t ST_MEMADR = 4'd2;
  localparam state_t ST_MEMRD  = 4'd3;
  localparam state_t ST_MEMWB  = 4'd4;
  localparam state_t ST_MEMWR  = 4'd5;
  localparam state_t ST_EXEC   = 4'd6;
  localparam state_t ST_RWB    = 4'd7;
  localparam state_t ST_BRANCH = 4'd8;
  localparam state_t ST_JUMP   = 4'd9;
  localparam state_t ST_ADDIEX = 4'd10;
  localparam state_t ST_ADDIWB = 4'd11;

  // Supported opcodes (instruction[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic [1:0] pc_source;
    logic [1:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       reg_write;
    logic       reg_dst;
    logic       instr_done;
    logic       illegal_op;
  } ctrl_t;

  function automatic logic op_legal(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
  endfunction

endpackage

// File: rtl/mc_ctrl_outdec.sv
// Combinational state -> control-word decode for the multicycle controller.
// Ports:
//   state   in   4   current FSM state
//   op      in   6   opcode, only used to flag illegal ops in DECODE
//   mem_ok  in   1   memory access complete (tied high when wait states are disabled)
//   ctrl    out  -   full control word (ctrl_t)
module mc_ctrl_outdec
  import mc_ctrl_pkg::*;
(
  input  state_t     state,
  input  logic [5:0] op,
  input  logic       mem_ok,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      ST_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_source = PCSRC_ALU;
        // IR and PC only commit once the fetch data is actually available
        ctrl.ir_write  = mem_ok;
        ctrl.pc_write  = mem_ok;
      end
      ST_DECODE: begin
        ctrl.alu_src_b  = SRCB_IMM_SH;
        ctrl.alu_op     = ALUOP_ADD;
        ctrl.illegal_op = !op_legal(op);
      end
      ST_MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      ST_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      ST_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      ST_MEMWR: begin
        ctrl.mem_write  = 1'b1;
        ctrl.i_or_d     = 1'b1;
        ctrl.instr_done = mem_ok;
      end
      ST_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_B;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      ST_RWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      ST_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_B;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
        ctrl.instr_done    = 1'b1;
      end
      ST_JUMP: begin
        ctrl.pc_write   = 1'b1;
        ctrl.pc_source  = PCSRC_JUMP;
        ctrl.instr_done = 1'b1;
      end
      ST_ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      ST_ADDIWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore FSM sequencing the MIPS multicycle datapath (3-5 cycles per instruction)
// plus a retired-instruction counter for bring-up.
// Optional feature: define MC_MEM_WAIT_EN to make FETCH/MEMRD/MEMWR wait for mem_ready.
// Ports:
//   clk, reset (sync, active-high), Op[5:0], mem_ready
//   PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, PCSource[1:0],
//   ALUOp[1:0], ALUSrcA, ALUSrcB[1:0], RegWrite, RegDst   datapath controls
//   instr_done, illegal_op   status pulses;  retired[CNT_W-1:0]   retired count
module multicycle_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       Op,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             MemtoReg,
  output logic [1:0]       PCSource,
  output logic [1:0]       ALUOp,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic             RegWrite,
  output logic             RegDst,
  output logic             instr_done,
  output logic             illegal_op,
  output logic [CNT_W-1:0] retired
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] retired_q;
  logic             mem_ok;
  ctrl_t            ctrl, ctrl_out;

`ifdef MC_MEM_WAIT_EN
  assign mem_ok = mem_ready;
`else
  // Memory states always complete in one cycle; mem_ready is deliberately ignored
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready;
  assign mem_ok = 1'b1;
`endif

  always_comb begin
    state_d = ST_FETCH;
    case (state_q)
      ST_FETCH:  state_d = mem_ok ? ST_DECODE : ST_FETCH;
      ST_DECODE: begin
        case (Op)
          OP_LW, OP_SW: state_d = ST_MEMADR;
          OP_RTYPE:     state_d = ST_EXEC;
          OP_BEQ:       state_d = ST_BRANCH;
          OP_J:         state_d = ST_JUMP;
          OP_ADDI:      state_d = ST_ADDIEX;
          default:      state_d = ST_FETCH;
        endcase
      end
      ST_MEMADR: state_d = (Op == OP_LW) ? ST_MEMRD : ST_MEMWR;
      ST_MEMRD:  state_d = mem_ok ? ST_MEMWB : ST_MEMRD;
      ST_MEMWR:  state_d = mem_ok ? ST_FETCH : ST_MEMWR;
      ST_EXEC:   state_d = ST_RWB;
      ST_ADDIEX: state_d = ST_ADDIWB;
      default:   state_d = ST_FETCH;
    endcase
  end

  mc_ctrl_outdec u_outdec (
    .state  (state_q),
    .op     (Op),
    .mem_ok (mem_ok),
    .ctrl   (ctrl)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_FETCH;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (ctrl.instr_done) begin
        retired_q <= retired_q + CNT_W'(1);
      end
    end
  end

  // Every output is held low while reset is asserted
  assign ctrl_out = reset ? '0 : ctrl;

  assign PCWrite     = ctrl_out.pc_write;
  assign PCWriteCond = ctrl_out.pc_write_cond;
  assign IorD        = ctrl_out.i_or_d;
  assign MemRead     = ctrl_out.mem_read;
  assign MemWrite    = ctrl_out.mem_write;
  assign IRWrite     = ctrl_out.ir_write;
  assign MemtoReg    = ctrl_out.mem_to_reg;
  assign PCSource    = ctrl_out.pc_source;
  assign ALUOp       = ctrl_out.alu_op;
  assign ALUSrcA     = ctrl_out.alu_src_a;
  assign ALUSrcB     = ctrl_out.alu_src_b;
  assign RegWrite    = ctrl_out.reg_write;
  assign RegDst      = ctrl_out.reg_dst;
  assign instr_done  = ctrl_out.instr_done;
  assign illegal_op  = ctrl_out.illegal_op;
  assign retired     = reset ? '0 : retired_q;

endmodule
